// File: rtl/usb_rx_if.sv
// usb_rx_if: bundles the USB receive path's pad, buffer and status signals.
//   slave  : receiver side (usb_rx). Takes the raw D+/D- lines and buffer
//            occupancy. Drives the PID/status outputs and the buffer write port.
//   master : environment side (pads, data buffer, protocol controller).
interface usb_rx_if;
  logic       dplus_in;
  logic       dminus_in;
  logic [6:0] buff_occ;
  logic [2:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       flush;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;

  modport slave (
    input  dplus_in, dminus_in, buff_occ,
    output rx_packet, rx_data_ready, rx_transfer_active, rx_error,
           flush, store_rx_packet_data, rx_packet_data
  );

  modport master (
    output dplus_in, dminus_in, buff_occ,
    input  rx_packet, rx_data_ready, rx_transfer_active, rx_error,
           flush, store_rx_packet_data, rx_packet_data
  );
endinterface

// File: rtl/usb_rx.sv
// usb_rx: full-speed USB receive path.
// Synchronizes D+/D-, recovers bit timing with a phase counter, NRZI-decodes,
// removes stuffed bits and walks SYNC -> PID -> TOKEN/DATA -> EOP.
// Payload bytes, including the CRC16 bytes, are written to the data buffer.
// Packet status goes to the protocol controller.
// Ports:
//   clk    : system clock (CLKS_PER_BIT clocks per USB bit)
//   n_rst  : synchronous active-low reset
//   bus    : usb_rx_if.slave carrying
//            dplus_in/dminus_in (raw lines), buff_occ (buffer fill),
//            rx_packet (PID code), rx_data_ready (clean end pulse),
//            rx_transfer_active, rx_error (sticky until next SOP),
//            flush (DATA PID accepted), store_rx_packet_data/rx_packet_data.
module usb_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3,
  parameter int BUFF_DEPTH   = 64
) (
  input logic     clk,
  input logic     n_rst,
  usb_rx_if.slave bus
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PH_MAX    = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_PID   = 3'd2,
    S_TOKEN = 3'd3,
    S_DATA  = 3'd4,
    S_EOP   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  // Maps a received PID byte to its status code. Returns 0 when the PID is illegal.
  function automatic logic [2:0] pid_decode(input logic [7:0] pid);
    logic [2:0] code;
    code = 3'd0;
    if (pid[3:0] == ~pid[7:4]) begin
      case (pid)
        8'hE1:   code = 3'd1;  // OUT
        8'h69:   code = 3'd2;  // IN
        8'hC3:   code = 3'd3;  // DATA0
        8'h4B:   code = 3'd4;  // DATA1
        8'hD2:   code = 3'd5;  // ACK
        8'h5A:   code = 3'd6;  // NAK
        8'h1E:   code = 3'd7;  // STALL
        default: code = 3'd0;
      endcase
    end else begin
      code = 3'd0;
    end
    return code;
  endfunction

  // Synchronizer and bit-timing state
  logic          dp_meta_r, dp_r, dm_meta_r, dm_r;
  logic          dp_prev_r;
  logic [PW-1:0] phase_r;

  // Decoder / FSM state
  state_t        state_r;
  logic          last_dp_r;   // dp at the previous sample point (NRZI reference)
  logic [2:0]    ones_r;      // consecutive decoded 1s, for unstuffing
  logic [2:0]    bit_cnt_r;   // bit position within the current byte
  logic [7:0]    shift_r;
  logic          tok_byte_r;  // second token byte in progress
  logic [1:0]    eop_cnt_r;   // SE0 samples seen in EOP
  logic [2:0]    j_cnt_r;     // consecutive J samples while in ERR

  // Registered outputs
  logic [2:0]    rx_packet_r;
  logic          rx_data_ready_r;
  logic          rx_transfer_active_r;
  logic          rx_error_r;
  logic          flush_r;
  logic          store_r;
  logic [7:0]    rx_data_r;

  // Combinational decode helpers
  logic          edge_s, sample_s, se0_s, j_s, sop_s;
  logic          nrzi_bit_s, stuff_slot_s, overflow_s;
  logic [7:0]    byte_s;
  logic [2:0]    pid_code_s;

  // Two-flop synchronizers on the raw lines; reset to idle J
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dp_meta_r <= 1'b1;
      dp_r      <= 1'b1;
      dm_meta_r <= 1'b0;
      dm_r      <= 1'b0;
    end else begin
      dp_meta_r <= bus.dplus_in;
      dp_r      <= dp_meta_r;
      dm_meta_r <= bus.dminus_in;
      dm_r      <= dm_meta_r;
    end
  end

  // Phase counter: realigns to every dp transition, otherwise free-runs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dp_prev_r <= 1'b1;
      phase_r   <= '0;
    end else begin
      dp_prev_r <= dp_r;
      if (edge_s) begin
        phase_r <= '0;
      end else if (phase_r == PH_MAX) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + PW'(1);
      end
    end
  end

  // Line-state, NRZI and byte-assembly decode for the current cycle
  always_comb begin
    edge_s       = (dp_r != dp_prev_r);
    // A sample coinciding with a realignment would land on the edge itself
    sample_s     = (phase_r == PH_SAMPLE) && !edge_s;
    se0_s        = !dp_r && !dm_r;
    j_s          = dp_r && !dm_r;
    sop_s        = dp_prev_r && !dp_r && dm_r;
    nrzi_bit_s   = (dp_r == last_dp_r);
    stuff_slot_s = (ones_r == 3'd6);
    byte_s       = {nrzi_bit_s, shift_r[7:1]};
    pid_code_s   = pid_decode(byte_s);
    overflow_s   = (bus.buff_occ == 7'(BUFF_DEPTH));
  end

  // Receive FSM with registered status and buffer-write outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r              <= S_IDLE;
      last_dp_r            <= 1'b1;
      ones_r               <= 3'd0;
      bit_cnt_r            <= 3'd0;
      shift_r              <= 8'h00;
      tok_byte_r           <= 1'b0;
      eop_cnt_r            <= 2'd0;
      j_cnt_r              <= 3'd0;
      rx_packet_r          <= 3'd0;
      rx_data_ready_r      <= 1'b0;
      rx_transfer_active_r <= 1'b0;
      rx_error_r           <= 1'b0;
      flush_r              <= 1'b0;
      store_r              <= 1'b0;
      rx_data_r            <= 8'h00;
    end else begin
      rx_data_ready_r <= 1'b0;
      flush_r         <= 1'b0;
      store_r         <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // The idle line is J, so the first SYNC bit decodes against J
          last_dp_r  <= 1'b1;
          ones_r     <= 3'd0;
          bit_cnt_r  <= 3'd0;
          tok_byte_r <= 1'b0;
          eop_cnt_r  <= 2'd0;
          j_cnt_r    <= 3'd0;
          if (sop_s) begin
            state_r              <= S_SYNC;
            rx_transfer_active_r <= 1'b1;
            rx_error_r           <= 1'b0;
            rx_packet_r          <= 3'd0;
          end else begin
            state_r <= S_IDLE;
          end
        end

        S_SYNC, S_PID, S_TOKEN, S_DATA: begin
          if (sample_s) begin
            if (se0_s) begin
              // In DATA a byte-aligned SE0 is the first half of EOP
              if ((state_r == S_DATA) && (bit_cnt_r == 3'd0)) begin
                state_r   <= S_EOP;
                eop_cnt_r <= 2'd1;
              end else begin
                state_r              <= S_ERR;
                rx_error_r           <= 1'b1;
                rx_transfer_active_r <= 1'b0;
                j_cnt_r              <= 3'd0;
              end
            end else if (stuff_slot_s) begin
              last_dp_r <= dp_r;
              if (nrzi_bit_s) begin
                state_r              <= S_ERR;
                rx_error_r           <= 1'b1;
                rx_transfer_active_r <= 1'b0;
                j_cnt_r              <= 3'd0;
              end else begin
                ones_r <= 3'd0;
              end
            end else begin
              last_dp_r <= dp_r;
              ones_r    <= nrzi_bit_s ? (ones_r + 3'd1) : 3'd0;
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                case (state_r)
                  S_SYNC: begin
                    if (byte_s == 8'h80) begin
                      state_r <= S_PID;
                    end else begin
                      state_r              <= S_ERR;
                      rx_error_r           <= 1'b1;
                      rx_transfer_active_r <= 1'b0;
                      j_cnt_r              <= 3'd0;
                    end
                  end
                  S_PID: begin
                    if (pid_code_s == 3'd0) begin
                      state_r              <= S_ERR;
                      rx_error_r           <= 1'b1;
                      rx_transfer_active_r <= 1'b0;
                      j_cnt_r              <= 3'd0;
                    end else begin
                      rx_packet_r <= pid_code_s;
                      case (pid_code_s)
                        3'd1, 3'd2: begin
                          state_r    <= S_TOKEN;
                          tok_byte_r <= 1'b0;
                        end
                        3'd3, 3'd4: begin
                          state_r <= S_DATA;
                          flush_r <= 1'b1;
                        end
                        default: begin
                          state_r   <= S_EOP;
                          eop_cnt_r <= 2'd0;
                        end
                      endcase
                    end
                  end
                  S_TOKEN: begin
                    if (tok_byte_r) begin
                      state_r   <= S_EOP;
                      eop_cnt_r <= 2'd0;
                    end else begin
                      tok_byte_r <= 1'b1;
                    end
                  end
                  S_DATA: begin
                    // A full buffer drops the byte and aborts the packet
                    if (overflow_s) begin
                      state_r              <= S_ERR;
                      rx_error_r           <= 1'b1;
                      rx_transfer_active_r <= 1'b0;
                      j_cnt_r              <= 3'd0;
                    end else begin
                      store_r   <= 1'b1;
                      rx_data_r <= byte_s;
                    end
                  end
                  default: begin
                    state_r              <= S_ERR;
                    rx_error_r           <= 1'b1;
                    rx_transfer_active_r <= 1'b0;
                    j_cnt_r              <= 3'd0;
                  end
                endcase
              end
            end
          end
        end

        S_EOP: begin
          if (sample_s) begin
            if (se0_s && (eop_cnt_r < 2'd2)) begin
              eop_cnt_r <= eop_cnt_r + 2'd1;
            end else if (j_s && (eop_cnt_r == 2'd2)) begin
              state_r              <= S_DONE;
              rx_data_ready_r      <= 1'b1;
              rx_transfer_active_r <= 1'b0;
            end else if (!se0_s && (eop_cnt_r == 2'd0) && stuff_slot_s && !nrzi_bit_s) begin
              // Stuff bit trailing the last token/PID bit before SE0
              ones_r    <= 3'd0;
              last_dp_r <= dp_r;
            end else begin
              state_r              <= S_ERR;
              rx_error_r           <= 1'b1;
              rx_transfer_active_r <= 1'b0;
              j_cnt_r              <= 3'd0;
            end
          end
        end

        S_DONE: begin
          state_r <= S_IDLE;
        end

        S_ERR: begin
          // Stuffing limits a legal packet to 7 J bits in a row, so 8 means idle
          if (sample_s) begin
            if (j_s) begin
              if (j_cnt_r == 3'd7) begin
                state_r <= S_IDLE;
              end else begin
                j_cnt_r <= j_cnt_r + 3'd1;
              end
            end else begin
              j_cnt_r <= 3'd0;
            end
          end
        end

        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_packet            = rx_packet_r;
  assign bus.rx_data_ready        = rx_data_ready_r;
  assign bus.rx_transfer_active   = rx_transfer_active_r;
  assign bus.rx_error             = rx_error_r;
  assign bus.flush                = flush_r;
  assign bus.store_rx_packet_data = store_r;
  assign bus.rx_packet_data       = rx_data_r;

endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: scoreboard bench for usb_rx. Stimulus NRZI-encodes and bit-stuffs
// directed packets and pushes the expected events (flush, store byte, error
// rise, ready) into a queue. A monitor pops and compares whenever the DUT
// shows one of those events.
module tb_usb_rx;
  localparam int CPB = 8;

  localparam logic [1:0] EV_FLUSH = 2'd0;
  localparam logic [1:0] EV_STORE = 2'd1;
  localparam logic [1:0] EV_ERROR = 2'd2;
  localparam logic [1:0] EV_READY = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_if bus ();

  usb_rx #(
    .CLKS_PER_BIT(8),
    .SAMPLE_PHASE(3),
    .BUFF_DEPTH  (64)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic lvl;
  int   ones;

  function automatic logic [15:0] crc16_usb(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] c;
    logic [15:0] d;
    c = 16'hFFFF;
    d = {b1, b0};
    for (int i = 0; i < 16; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return ~c;
  endfunction

  task automatic expect_ev(input logic [1:0] k, input logic [7:0] v);
    exp_q.push_back(exp_t'({k, v}));
  endtask

  task automatic score(input logic [1:0] k, input logic [7:0] act, input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event, value=%02h, required no event", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != act) begin
        errors++;
        $display("FAIL %s: got kind=%0d value=%02h, required kind=%0d value=%02h",
                 name, k, act, e.kind, e.val);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.rx_packet, bus.rx_data_ready, bus.rx_transfer_active, bus.rx_error,
            bus.flush, bus.store_rx_packet_data, bus.rx_packet_data};
  endfunction

  // Monitor: every DUT event is matched against the next queued expectation
  initial begin
    logic prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.flush) score(EV_FLUSH, 8'h00, "flush");
      if (bus.store_rx_packet_data) score(EV_STORE, bus.rx_packet_data, "store");
      if (bus.rx_error && !prev_err) score(EV_ERROR, {5'd0, bus.rx_packet}, "error");
      if (bus.rx_data_ready)
        score(EV_READY, {bus.rx_error, bus.rx_transfer_active, 3'd0, bus.rx_packet}, "ready");
      prev_err = bus.rx_error;
    end
  end

  task automatic drive_level(input logic l);
    bus.dplus_in  = l;
    bus.dminus_in = ~l;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drive_se0();
    bus.dplus_in  = 1'b0;
    bus.dminus_in = 1'b0;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (!b) lvl = ~lvl;
    drive_level(lvl);
    if (b) begin
      ones++;
      if (ones == 6) begin
        lvl = ~lvl;
        drive_level(lvl);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] t;
    t = b;
    for (int i = 0; i < 8; i++) send_bit(t[i]);
  endtask

  task automatic start_packet();
    lvl  = 1'b1;
    ones = 0;
    send_byte(8'h80);
    check("active_after_sync", 32'(bus.rx_transfer_active), 32'd1);
  endtask

  task automatic end_packet();
    drive_se0();
    drive_se0();
    lvl = 1'b1;
    repeat (13) drive_level(1'b1);
  endtask

  initial begin
    logic [15:0] crc;
    logic [7:0]  tail;
    bus.dplus_in  = 1'b1;
    bus.dminus_in = 1'b0;
    bus.buff_occ  = 7'd0;
    lvl  = 1'b1;
    ones = 0;

    // Reset held with the lines toggling: outputs stay 0
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.dplus_in  = i[0];
      bus.dminus_in = ~i[0];
      check("reset_outputs", 32'(outs()), 32'd0);
    end
    bus.dplus_in  = 1'b1;
    bus.dminus_in = 1'b0;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check("idle_outputs", 32'(outs()), 32'd0);
    end

    // ACK
    expect_ev(EV_READY, 8'h05);
    start_packet();
    send_byte(8'hD2);
    end_packet();

    // DATA0 with 0x3F, 0xFF (forces a stuffed bit) and CRC16
    crc = crc16_usb(8'h3F, 8'hFF);
    expect_ev(EV_FLUSH, 8'h00);
    expect_ev(EV_STORE, 8'h3F);
    expect_ev(EV_STORE, 8'hFF);
    expect_ev(EV_STORE, crc[7:0]);
    expect_ev(EV_STORE, crc[15:8]);
    expect_ev(EV_READY, 8'h03);
    start_packet();
    send_byte(8'hC3);
    send_byte(8'h3F);
    send_byte(8'hFF);
    send_byte(crc[7:0]);
    send_byte(crc[15:8]);
    end_packet();

    // Bad PID 0xD3, then a clean NAK
    expect_ev(EV_ERROR, 8'h00);
    start_packet();
    send_byte(8'hD3);
    end_packet();
    expect_ev(EV_READY, 8'h06);
    start_packet();
    send_byte(8'h5A);
    end_packet();

    // DATA1 into a full buffer: no stores, error with PID DATA1
    bus.buff_occ = 7'd64;
    expect_ev(EV_FLUSH, 8'h00);
    expect_ev(EV_ERROR, 8'h04);
    start_packet();
    send_byte(8'h4B);
    send_byte(8'hA5);
    send_byte(8'h5A);
    end_packet();
    bus.buff_occ = 7'd0;

    // DATA0 with SE0 after 13 data bits
    expect_ev(EV_FLUSH, 8'h00);
    expect_ev(EV_STORE, 8'h55);
    expect_ev(EV_ERROR, 8'h03);
    start_packet();
    send_byte(8'hC3);
    send_byte(8'h55);
    tail = 8'h15;
    for (int i = 0; i < 5; i++) send_bit(tail[i]);
    end_packet();

    // Reset pulse in the middle of DATA
    expect_ev(EV_FLUSH, 8'h00);
    start_packet();
    send_byte(8'hC3);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    lvl = 1'b1;
    bus.dplus_in  = 1'b1;
    bus.dminus_in = 1'b0;
    repeat (3) @(negedge clk);
    check("active_before_reset", 32'(bus.rx_transfer_active), 32'd1);
    n_rst = 1'b0;
    @(negedge clk);
    check("outputs_after_reset", 32'(outs()), 32'd0);
    n_rst = 1'b1;
    repeat (20) drive_level(1'b1);

    // IN token after the aborted packet
    expect_ev(EV_READY, 8'h02);
    start_packet();
    send_byte(8'h69);
    send_byte(8'h01);
    send_byte(8'hE8);
    end_packet();

    repeat (50) @(negedge clk);
    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
